// File: rtl/seg_scan_sched.sv
// seg_scan_sched: 8-digit seven-segment scan scheduler arbitrating between
// a live source A frame and a latched source B frame granted at frame
// boundaries, with per-digit blinking.
// Optional build macro SEG_LZ_SUPPRESS_EN: blank leading zero digits
// (7 down to 1) of the active source frame.
module seg_scan_sched #(
    parameter int NUM_DIG  = 8,
    parameter int BLINK_MS = 500,
    parameter int HOLD_MS  = 2000
) (
    input  logic        clk_1kHz,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [39:0] a_digits,
    input  logic        b_req,
    input  logic [39:0] b_digits,
    input  logic [7:0]  blink_mask,
    output logic        b_ack,
    output logic        src_b,
    output logic [2:0]  cs_pointer,
    output logic [4:0]  dig_ctrl,
    output logic        blank
);

    localparam int HOLD_W  = $clog2(HOLD_MS + 1);
    localparam int BLINK_W = $clog2(BLINK_MS + 1);
    localparam logic [2:0]         LAST_DIG   = 3'(NUM_DIG - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_MS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

    typedef enum logic [1:0] {IDLE, SCAN_A, SCAN_B} state_t;

    state_t             state, state_nxt;
    logic [2:0]         ptr_nxt;
    logic [4:0]         dig_nxt;
    logic               blank_nxt, ack_nxt, srcb_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on, blink_on_nxt, blink_wrap;
    logic [39:0]        b_frame, frame_nxt, show_frame;
    logic [7:0]         supp_mask;
    logic               active, at_boundary;

    // Select the 5-bit code of one digit from a packed frame.
    function automatic logic [4:0] digit_of(input logic [39:0] frame, input logic [2:0] idx);
        return frame[5*idx +: 5];
    endfunction

    // Hold counter stops at its last value so an expired hold stays expired
    // until the scan reaches the frame boundary.
    function automatic logic [HOLD_W-1:0] hold_sat(input logic [HOLD_W-1:0] cnt);
        return (cnt == HOLD_LAST) ? cnt : cnt + 1'b1;
    endfunction

`ifdef SEG_LZ_SUPPRESS_EN
    // Digit k (k >= 1) is a leading zero when it and every higher digit are code 0.
    function automatic logic [7:0] lz_mask(input logic [39:0] frame);
        logic [7:0] m;
        logic       run;
        m   = '0;
        run = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            run  = run & (frame[5*k +: 5] == 5'd0);
            m[k] = run;
        end
        return m;
    endfunction
`endif

    assign blink_wrap   = (blink_cnt == BLINK_LAST);
    assign blink_on_nxt = blink_wrap ? ~blink_on : blink_on;
    assign at_boundary  = (cs_pointer == LAST_DIG);

    // Free-running blink timebase; the phase starts in the on half.
    always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_wrap) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Next state and next registered outputs; the digit view is computed for
    // the pointer value of the coming cycle so outputs stay aligned.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = cs_pointer;
        ack_nxt    = 1'b0;
        srcb_nxt   = src_b;
        hold_nxt   = hold_cnt;
        frame_nxt  = b_frame;
        show_frame = a_digits;
        active     = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            ptr_nxt   = 3'd0;
            srcb_nxt  = 1'b0;
            hold_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SCAN_A;
                    ptr_nxt   = 3'd0;
                    active    = 1'b1;
                end
                SCAN_A: begin
                    active = 1'b1;
                    if (at_boundary && b_req) begin
                        state_nxt  = SCAN_B;
                        ptr_nxt    = 3'd0;
                        ack_nxt    = 1'b1;
                        srcb_nxt   = 1'b1;
                        hold_nxt   = '0;
                        frame_nxt  = b_digits;
                        show_frame = b_digits;
                    end else begin
                        ptr_nxt = cs_pointer + 3'd1;
                    end
                end
                SCAN_B: begin
                    active     = 1'b1;
                    show_frame = b_frame;
                    if (at_boundary && (hold_cnt == HOLD_LAST)) begin
                        state_nxt  = SCAN_A;
                        ptr_nxt    = 3'd0;
                        srcb_nxt   = 1'b0;
                        hold_nxt   = '0;
                        show_frame = a_digits;
                    end else begin
                        ptr_nxt  = cs_pointer + 3'd1;
                        hold_nxt = hold_sat(hold_cnt);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    ptr_nxt   = 3'd0;
                    srcb_nxt  = 1'b0;
                    hold_nxt  = '0;
                end
            endcase
        end
`ifdef SEG_LZ_SUPPRESS_EN
        supp_mask = lz_mask(show_frame);
`else
        supp_mask = '0;
`endif
        if (active) begin
            dig_nxt   = digit_of(show_frame, ptr_nxt);
            blank_nxt = (~blink_on_nxt & blink_mask[ptr_nxt]) | supp_mask[ptr_nxt];
        end else begin
            dig_nxt   = 5'd0;
            blank_nxt = 1'b1;
        end
    end

    // State, B latch and registered outputs.
    always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cs_pointer <= 3'd0;
            dig_ctrl   <= 5'd0;
            blank      <= 1'b1;
            b_ack      <= 1'b0;
            src_b      <= 1'b0;
            hold_cnt   <= '0;
            b_frame    <= '0;
        end else begin
            state      <= state_nxt;
            cs_pointer <= ptr_nxt;
            dig_ctrl   <= dig_nxt;
            blank      <= blank_nxt;
            b_ack      <= ack_nxt;
            src_b      <= srcb_nxt;
            hold_cnt   <= hold_nxt;
            b_frame    <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Testbench for seg_scan_sched: table-driven frame checks, hand-written
// grant / abort / reset / blink sequences, and a randomized run checked
// against a behavioural model. Honours SEG_LZ_SUPPRESS_EN like the design.
module tb_seg_scan_sched;

    localparam int BLINK_MS = 500;
    localparam int HOLD_MS  = 2000;

    logic        clk_1kHz = 1'b0;
    logic        rst_n    = 1'b0;
    logic        enable   = 1'b0;
    logic        b_req    = 1'b0;
    logic [39:0] a_digits = '0;
    logic [39:0] b_digits = '0;
    logic [7:0]  blink_mask = '0;
    logic        b_ack, src_b, blank;
    logic [2:0]  cs_pointer;
    logic [4:0]  dig_ctrl;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_sched #(.NUM_DIG(8), .BLINK_MS(BLINK_MS), .HOLD_MS(HOLD_MS)) dut (
        .clk_1kHz   (clk_1kHz),
        .rst_n      (rst_n),
        .enable     (enable),
        .a_digits   (a_digits),
        .b_req      (b_req),
        .b_digits   (b_digits),
        .blink_mask (blink_mask),
        .b_ack      (b_ack),
        .src_b      (src_b),
        .cs_pointer (cs_pointer),
        .dig_ctrl   (dig_ctrl),
        .blank      (blank)
    );

    always #5 clk_1kHz = ~clk_1kHz;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Behavioural model: mode 0 = idle, 1 = source A, 2 = source B.
    int          m_mode, m_ptr, m_held, m_t;
    logic        m_ack, m_srcb;
    logic [39:0] m_bframe;

    typedef struct {
        logic [39:0] a;
        logic [7:0]  blank_lz;
        logic [7:0]  blank_plain;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [4:0] field(input logic [39:0] f, input int k);
        return f[5*k +: 5];
    endfunction

    function automatic logic [39:0] pack8(input logic [4:0] d7, d6, d5, d4, d3, d2, d1, d0);
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    function automatic logic [39:0] rand_frame();
        logic [39:0] f;
        f = '0;
        for (int k = 0; k < 8; k++)
            if ($urandom_range(0, 1) == 1) f[5*k +: 5] = 5'($urandom_range(0, 31));
        return f;
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_held = 0; m_t = 0;
        m_ack = 1'b0; m_srcb = 1'b0; m_bframe = '0;
    endtask

    // One clock of the scheduling rules, evaluated on the inputs at the edge.
    task automatic model_step();
        m_t++;
        m_ack = 1'b0;
        if (!enable) begin
            m_mode = 0; m_ptr = 0; m_srcb = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_ptr = 0;
        end else if (m_mode == 1) begin
            if (m_ptr == 7 && b_req) begin
                m_mode = 2; m_ptr = 0; m_ack = 1'b1; m_srcb = 1'b1;
                m_bframe = b_digits; m_held = 1;
            end else begin
                m_ptr = (m_ptr + 1) % 8;
            end
        end else begin
            if (m_held >= HOLD_MS && m_ptr == 7) begin
                m_mode = 1; m_ptr = 0; m_srcb = 1'b0;
            end else begin
                m_ptr = (m_ptr + 1) % 8;
                m_held++;
            end
        end
    endtask

    task automatic check_all();
        logic [39:0] fr;
        logic [4:0]  ed;
        logic        eb, supp, phase_on;
        if (m_mode == 0) begin
            ed = 5'd0; eb = 1'b1;
        end else begin
            fr       = (m_mode == 2) ? m_bframe : a_digits;
            ed       = field(fr, m_ptr);
            phase_on = ((m_t / BLINK_MS) % 2) == 0;
            supp     = 1'b0;
`ifdef SEG_LZ_SUPPRESS_EN
            if (m_ptr > 0) begin
                supp = 1'b1;
                for (int j = m_ptr; j < 8; j++) if (field(fr, j) != 5'd0) supp = 1'b0;
            end
`endif
            eb = (!phase_on && blink_mask[m_ptr]) || supp;
        end
        chk("model cs_pointer", 40'(cs_pointer), 40'(m_ptr));
        chk("model dig_ctrl", 40'(dig_ctrl), 40'(ed));
        chk("model blank", 40'(blank), 40'(eb));
        chk("model b_ack", 40'(b_ack), 40'(m_ack));
        chk("model src_b", 40'(src_b), 40'(m_srcb));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_1kHz);
        #1;
        check_all();
    endtask

    task automatic wait_ptr(input int p, input string name);
        int n;
        n = 0;
        while (cs_pointer != 3'(p) && n < 16) begin
            tick();
            n++;
        end
        chk(name, 40'(cs_pointer), 40'(p));
    endtask

    initial begin
        int cnt, acks, blank0, blank_other;

        vecs[0] = '{pack8(5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0), 8'h00, 8'h00};
        vecs[1] = '{pack8(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0), 8'hF8, 8'h00};
        vecs[2] = '{pack8(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0), 8'hFE, 8'h00};
        vecs[3] = '{pack8(5'd0, 5'h10, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3), 8'h80, 8'h00};
        vecs[4] = '{pack8(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'h1F, 5'd0), 8'hFC, 8'h00};

        // Power-up reset
        model_reset();
        repeat (3) @(posedge clk_1kHz);
        #1;
        check_all();
        rst_n = 1'b1;

        // Table-driven frames: pointer sequence, digit codes, suppression
        enable = 1'b1;
        tick();
        for (int v = 0; v < 5; v++) begin
            a_digits = vecs[v].a;
            wait_ptr(7, "table align");
            for (int i = 0; i < 8; i++) begin
                logic [7:0] eb;
`ifdef SEG_LZ_SUPPRESS_EN
                eb = vecs[v].blank_lz;
`else
                eb = vecs[v].blank_plain;
`endif
                tick();
                chk("table cs_pointer", 40'(cs_pointer), 40'(i));
                chk("table dig_ctrl", 40'(dig_ctrl), 40'(field(vecs[v].a, i)));
                chk("table blank", 40'(blank), 40'(eb[i]));
            end
        end

        // Grant at frame boundary, 2000-cycle hold, minimum A frame before regrant
        a_digits = vecs[0].a;
        b_digits = pack8(5'h1A, 5'h0B, 5'h1C, 5'h0D, 5'h0E, 5'h0F, 5'h19, 5'h08);
        wait_ptr(3, "grant align");
        b_req = 1'b1;
        wait_ptr(7, "grant boundary");
        chk("no early b_ack", 40'(b_ack), 40'd0);
        tick();
        chk("grant b_ack", 40'(b_ack), 40'd1);
        chk("grant src_b", 40'(src_b), 40'd1);
        chk("grant cs_pointer", 40'(cs_pointer), 40'd0);
        chk("grant dig_ctrl", 40'(dig_ctrl), 40'h08);
        cnt = 1;
        while (src_b && cnt < HOLD_MS + 100) begin
            tick();
            if (src_b) cnt++;
        end
        chk("hold length", 40'(cnt), 40'(HOLD_MS));
        cnt = 0;
        while (!b_ack && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("A frame before regrant", 40'(cnt), 40'd8);

        // Enable dropped mid B hold
        repeat (100) tick();
        enable = 1'b0;
        tick();
        chk("abort src_b", 40'(src_b), 40'd0);
        chk("abort blank", 40'(blank), 40'd1);
        chk("abort cs_pointer", 40'(cs_pointer), 40'd0);
        acks = 0;
        repeat (20) begin
            tick();
            acks += int'(b_ack);
        end
        chk("abort no b_ack", 40'(acks), 40'd0);

        // Enable and b_req falling/rising together at the boundary
        b_req = 1'b0;
        enable = 1'b1;
        tick();
        wait_ptr(7, "prio align");
        b_req = 1'b1;
        enable = 1'b0;
        tick();
        chk("prio b_ack", 40'(b_ack), 40'd0);
        chk("prio src_b", 40'(src_b), 40'd0);
        chk("prio cs_pointer", 40'(cs_pointer), 40'd0);

        // Asynchronous reset during B hold
        enable = 1'b1;
        cnt = 0;
        while (!src_b && cnt < 30) begin
            tick();
            cnt++;
        end
        chk("reach B", 40'(src_b), 40'd1);
        b_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("reset dig_ctrl", 40'(dig_ctrl), 40'd0);
        @(posedge clk_1kHz);
        #1;
        rst_n = 1'b1;

        // Blink on digit 0 from a fresh timebase
        a_digits = pack8(5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1);
        blink_mask = 8'h01;
        blank0 = 0;
        blank_other = 0;
        for (int t = 1; t < 1200; t++) begin
            tick();
            if (blank && cs_pointer == 3'd0) blank0++;
            if (blank && cs_pointer != 3'd0) blank_other++;
        end
        chk("blink digit0 dark cycles", 40'(blank0), 40'd62);
        chk("blink other digits", 40'(blank_other), 40'd0);

        // Randomized run against the model
        for (int n = 0; n < 20000; n++) begin
            enable = ($urandom_range(0, 2999) != 0);
            b_req  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) a_digits = rand_frame();
            if ($urandom_range(0, 15) == 0) b_digits = rand_frame();
            if ($urandom_range(0, 299) == 0) blink_mask = 8'($urandom_range(0, 255));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
